// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, bench clock period and loader states.
package cpu_pkg;

  localparam int unsigned WORD      = 32;
  localparam int unsigned INSTR_LEN = 32;
  localparam int unsigned CYCLE     = 10;
  localparam int unsigned BYTE_W    = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEADER,
    ST_LOAD,
    ST_WRITE,
    ST_DONE,
    ST_ERR
  } loader_state_t;

endpackage

// File: rtl/byte_assembler.sv
// Little-endian 8-to-32 packer. The first three bytes are held in acc.
// `word` is a preview of the full word with the current in_data placed in the
// lane selected by idx, so the caller can capture the finished word on the
// same edge that accepts the fourth byte.
module byte_assembler
  import cpu_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 load,
  input  logic [BYTE_W-1:0]    in_data,
  output logic [INSTR_LEN-1:0] word,
  output logic                 last
);

  logic [1:0]  idx;
  logic [23:0] acc;

  // Byte index and storage for the lower three lanes.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      idx <= '0;
      acc <= '0;
    end else if (load) begin
      idx <= idx + 2'd1;
      case (idx)
        2'd0:    acc[7:0]   <= in_data;
        2'd1:    acc[15:8]  <= in_data;
        2'd2:    acc[23:16] <= in_data;
        default: ;
      endcase
    end
  end

  // Merge the current byte into its lane.
  always_comb begin
    word = {8'h00, acc};
    case (idx)
      2'd0:    word[7:0]   = in_data;
      2'd1:    word[15:8]  = in_data;
      2'd2:    word[23:16] = in_data;
      default: word[31:24] = in_data;
    endcase
  end

  assign last = (idx == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed little-endian program into instruction memory,
// holding the processor in reset until the whole program is written.
module imem_loader
  import cpu_pkg::*;
#(
  parameter int unsigned SIZE = 16,
  parameter int unsigned AW   = $clog2(SIZE)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 in_valid,
  input  logic [7:0]           in_data,
  output logic                 in_ready,
  output logic                 imem_we,
  output logic [AW-1:0]        imem_addr,
  output logic [INSTR_LEN-1:0] imem_wdata,
  output logic                 cpu_reset,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [AW:0]          word_count
);

  localparam int unsigned CW = AW + 1;

  loader_state_t        state;
  logic [CW-1:0]        n_q;
  logic [CW-1:0]        count_inc;
  logic                 accept;
  logic                 hdr_bad;
  logic                 asm_clear;
  logic                 asm_load;
  logic                 asm_last;
  logic [INSTR_LEN-1:0] asm_word;

  assign accept    = in_valid & in_ready;
  assign hdr_bad   = (in_data == 8'd0) || (32'(in_data) > 32'(SIZE));
  assign asm_clear = (state == ST_HEADER) && accept;
  assign asm_load  = (state == ST_LOAD) && accept;
  assign count_inc = word_count + CW'(1);

  byte_assembler u_asm (
    .clk     (clk),
    .reset   (reset),
    .clear   (asm_clear),
    .load    (asm_load),
    .in_data (in_data),
    .word    (asm_word),
    .last    (asm_last)
  );

  // Loader FSM; every output is registered alongside the state it belongs to.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      in_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_reset  <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      word_count <= '0;
      n_q        <= '0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            state     <= ST_HEADER;
            in_ready  <= 1'b1;
            busy      <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
            cpu_reset <= 1'b1;
          end
        end
        ST_HEADER: begin
          if (accept) begin
            if (hdr_bad) begin
              state    <= ST_ERR;
              in_ready <= 1'b0;
              busy     <= 1'b0;
              error    <= 1'b1;
            end else begin
              n_q        <= CW'(in_data);
              word_count <= '0;
              state      <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          if (accept && asm_last) begin
            state      <= ST_WRITE;
            in_ready   <= 1'b0;
            imem_we    <= 1'b1;
            imem_addr  <= word_count[AW-1:0];
            imem_wdata <= asm_word;
          end
        end
        ST_WRITE: begin
          word_count <= count_inc;
          if (count_inc == n_q) begin
            state     <= ST_DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            cpu_reset <= 1'b0;
          end else begin
            state    <= ST_LOAD;
            in_ready <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Writes a program into the instruction memory read by `iFetch`. Accepts a byte stream over a valid/ready handshake: one length header, then the instructions as little-endian 32-bit words. Holds the processor in reset while loading, then releases it so `iFetch` starts at PC 0. Lets benches and bring-up load programs such as the division routine without recompiling memory init files.

## Interface
Parameters:
- `SIZE`, 16: instruction memory depth in `INSTR_LEN`-bit words; must match `iFetch` `SIZE`.
- `AW`, `$clog2(SIZE)`: word-address width (derived; do not override).

Ports:
- `clk`  in  1  system clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- `start`  in  1  one-cycle pulse; begins a load from IDLE, DONE or ERR.
- `in_valid`  in  1  source has a byte on `in_data`.
- `in_data`  in  8  stream byte.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `imem_we`  out  1  one-cycle write strobe to instruction memory.
- `imem_addr`  out  AW  word index (PC >> 2) for the write.
- `imem_wdata`  out  `INSTR_LEN`  instruction word.
- `cpu_reset`  out  1  drives the processor `reset`; high except in DONE.
- `busy`  out  1  high in HEADER, LOAD, WRITE.
- `done`  out  1  high in DONE.
- `error`  out  1  high in ERR.
- `word_count`  out  AW+1  words written in the current load.

## Operation
- Byte transfer occurs when `in_valid && in_ready`. `in_data` is ignored otherwise.
- States: IDLE, HEADER, LOAD, WRITE, DONE, ERR.
- IDLE: `cpu_reset`=1. `start` -> HEADER.
- HEADER: `in_ready`=1. Accepted byte N is latched.
  - N=0 or N>SIZE -> ERR.
  - Otherwise clear `word_count` and the byte index -> LOAD.
- LOAD: `in_ready`=1. Bytes pack little-endian:
  - first byte -> bits [7:0], second -> [15:8], third -> [23:16], fourth -> [31:24].
  - Acceptance of the 4th byte -> WRITE.
- WRITE: `in_ready`=0, `imem_we`=1, `imem_addr`=`word_count[AW-1:0]`, `imem_wdata`=assembled word. `word_count` increments on exit.
  - Next state is DONE if the incremented count equals N, else LOAD.
- DONE: `cpu_reset`=0, `done`=1. Holds until `start` (-> HEADER, `cpu_reset` back to 1) or `reset`.
- ERR: `error`=1, `cpu_reset`=1. `start` -> HEADER. Memory is not written.
- `start` in HEADER, LOAD or WRITE is ignored. A stalled source (`in_valid`=0) holds state indefinitely with no timeout.
- Partial load: words already written stay in memory. The processor stays in reset.
- `imem_addr` and `imem_wdata` hold their last values outside WRITE. Only `imem_we` qualifies them.

## Timing
- Reset values: `in_ready`=0, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `cpu_reset`=1, `busy`=0, `done`=0, `error`=0, `word_count`=0, state IDLE.
- All outputs are registered or decoded from registered state. There is no combinational path from `in_valid` to `in_ready`.
- `start` at edge k: HEADER and `in_ready`=1 from cycle k+1.
- The 4th byte of a word accepted at edge k: `imem_we`=1 during cycle k+1, and `in_ready`=0 during k+1.
- Best case per word is 5 cycles (4 accept + 1 write). An N-word load completes in 1 + 5N cycles after HEADER entry.
- `cpu_reset` falls on the edge that enters DONE. The processor sees its first non-reset edge one cycle later, with PC=0.
- `reset` in any state: IDLE at the next edge. Any in-flight word is discarded, and `imem_we` is 0 in the following cycle.

## Structure
- Shared package `cpu_pkg`: `loader_state_t` enum, plus the existing `WORD`, `INSTR_LEN` and `CYCLE` definitions. No new macros.
- Sub-module `byte_assembler`:
  - 8-to-32 little-endian packer with a 2-bit byte index.
  - Ports: `clk`, `reset`, `clear`, `load`, `in_data`, `word`, `last`.
  - `last` is high when the index is 3.
- The top level holds the FSM, `word_count` and the N register.

## Test plan
- One-word load: `start`; bytes 01, E1, 17, 00, 91 -> one `imem_we` with `imem_addr`=0 and `imem_wdata`=0x910017E1 (ADDI X1,X31,#5). Then `done`=1, `cpu_reset`=0, `word_count`=1.
- Full load: header 16, then 64 bytes with word i = 0x8B000000+i -> 16 strobes at addr 0..15 in order. `done` rises exactly 81 cycles after HEADER entry.
- Bad headers: header 0 -> `error`=1. Header 17 (SIZE=16) -> `error`=1. In both cases no `imem_we` pulse and `cpu_reset`=1. A following `start` then a valid load reaches DONE.
- Backpressure: `in_valid` toggled randomly -> identical write sequence to the gap-free run. `in_ready`=0 in every WRITE cycle.
- `reset` asserted after the 2nd byte of word 1 (header 3) -> IDLE next cycle; word 0 remains in memory; no further strobes. A fresh load then overwrites from addr 0.
- `start` pulsed during LOAD -> ignored; the write sequence is unchanged.
